// File: rtl/auto_gearbox_ctrl_if.sv
// rtl/auto_gearbox_ctrl_if.sv - signal bundle between driver inputs and gearbox controller
//
// Purpose: groups the gearbox controller's driver-side inputs and indicator/clutch
// outputs so they travel as one port.
// Parameters: NUM_GEARS (forward gears), SPEED_W (speed width).
// Signals:
//   drive, manual, up_req, down_req, kickdown, speed  -> toward the controller
//   gear, clutch, denied                               <- from the controller
// Modports: master = input logic / stimulus side, slave = controller side.
interface auto_gearbox_ctrl_if #(
    parameter int NUM_GEARS = 4,
    parameter int SPEED_W   = 8
);
    localparam int GW = $clog2(NUM_GEARS + 1);

    logic               drive;
    logic               manual;
    logic               up_req;
    logic               down_req;
    logic               kickdown;
    logic [SPEED_W-1:0] speed;
    logic [GW-1:0]      gear;
    logic               clutch;
    logic               denied;

    modport master (
        output drive, manual, up_req, down_req, kickdown, speed,
        input  gear, clutch, denied
    );

    modport slave (
        input  drive, manual, up_req, down_req, kickdown, speed,
        output gear, clutch, denied
    );
endinterface

// File: rtl/auto_gearbox_ctrl.sv
// rtl/auto_gearbox_ctrl.sv - parametrised automatic/manual gearbox controller
//
// Purpose: selects the committed gear from vehicle speed, mode and driver requests,
// opening a timed clutch window for every single-step gear change.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - auto_gearbox_ctrl_if.slave:
//          drive/manual/up_req/down_req/kickdown/speed in,
//          gear (0 = neutral) / clutch / denied out, all registered.
module auto_gearbox_ctrl #(
    parameter int NUM_GEARS    = 4,
    parameter int SPEED_W      = 8,
    parameter int UP_STEP      = 40,
    parameter int HYST         = 8,
    parameter int SHIFT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    auto_gearbox_ctrl_if.slave  bus
);
    localparam int GW = $clog2(NUM_GEARS + 1);
    localparam int TW = SPEED_W + GW + 1;
    localparam int CW = (SHIFT_CYCLES > 1) ? $clog2(SHIFT_CYCLES) : 1;

    localparam logic [GW-1:0] GEAR_ONE = GW'(1);
    localparam logic [GW-1:0] GEAR_MAX = GW'(NUM_GEARS);
    localparam logic [TW-1:0] STEP_T   = TW'(UP_STEP);
    localparam logic [TW-1:0] HYST_T   = TW'(HYST);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SHIFT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_NEUTRAL = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_SHIFT   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] gear_q, gear_d;
    logic [GW-1:0] target_q, target_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clutch_q, clutch_d;
    logic          denied_q, denied_d;

    logic          go;
    logic [GW-1:0] go_target;
    logic          deny;

    // Threshold arithmetic. Dn(g) = Up(g-1) - HYST is never formed directly:
    // "speed < Dn(g)" is evaluated as "speed + HYST < Up(g-1)", which is simply
    // false whenever Dn(g) would be negative.
    logic [TW-1:0] speed_t;
    logic [TW-1:0] speed_h;
    logic [TW-1:0] up_cur;   // Up(g)   = base of Dn(g+1)
    logic [TW-1:0] up_prev;  // Up(g-1) = base of Dn(g); only meaningful for g >= 1

    assign speed_t = TW'(bus.speed);
    assign speed_h = speed_t + HYST_T;
    assign up_cur  = TW'(gear_q) * STEP_T;
    assign up_prev = up_cur - STEP_T;

    logic conflict;
    logic down_ev;
    logic can_down;
    logic can_up;

    assign conflict = bus.up_req & bus.down_req;
    assign down_ev  = bus.kickdown | (bus.manual & bus.down_req);
    assign can_down = (gear_q > GEAR_ONE) && (speed_t < up_prev);
    assign can_up   = (gear_q < GEAR_MAX) && !(speed_h < up_cur);

    // State register and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_NEUTRAL;
            gear_q   <= '0;
            target_q <= '0;
            cnt_q    <= '0;
            clutch_q <= 1'b0;
            denied_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gear_q   <= gear_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            clutch_q <= clutch_d;
            denied_q <= denied_d;
        end
    end

    // Next-state and shift decision
    always_comb begin
        state_d   = state_q;
        go        = 1'b0;
        go_target = gear_q;
        deny      = 1'b0;
        case (state_q)
            ST_NEUTRAL: begin
                if (bus.drive) state_d = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (!bus.drive) begin
                    state_d = ST_NEUTRAL;
                end else if (conflict) begin
                    // Contradictory buttons are refused outright, even in auto mode.
                    deny = 1'b1;
                end else if (down_ev) begin
                    if (can_down) begin
                        go        = 1'b1;
                        go_target = gear_q - GEAR_ONE;
                    end else begin
                        deny = 1'b1;
                    end
                end else if (bus.manual && bus.up_req) begin
                    if (can_up) begin
                        go        = 1'b1;
                        go_target = gear_q + GEAR_ONE;
                    end else begin
                        deny = 1'b1;
                    end
                end else if (!bus.manual) begin
                    if (speed_t >= up_cur && gear_q < GEAR_MAX) begin
                        go        = 1'b1;
                        go_target = gear_q + GEAR_ONE;
                    end else if (speed_h < up_prev && gear_q > GEAR_ONE) begin
                        go        = 1'b1;
                        go_target = gear_q - GEAR_ONE;
                    end
                end
                if (go) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (!bus.drive)          state_d = ST_NEUTRAL;
                else if (cnt_q == '0)    state_d = ST_DRIVE;
            end
            default: state_d = ST_NEUTRAL;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        gear_d   = gear_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        clutch_d = 1'b0;
        denied_d = 1'b0;
        case (state_q)
            ST_NEUTRAL: begin
                gear_d = bus.drive ? GEAR_ONE : '0;
                cnt_d  = '0;
            end
            ST_DRIVE: begin
                denied_d = deny;
                if (!bus.drive) begin
                    gear_d = '0;
                end else if (go) begin
                    // Clutch rises on the decision edge; the counter then spans
                    // the remaining SHIFT_CYCLES-1 edges before the commit edge.
                    clutch_d = 1'b1;
                    cnt_d    = CNT_LOAD;
                    target_d = go_target;
                end
            end
            ST_SHIFT: begin
                if (!bus.drive) begin
                    gear_d = '0;
                    cnt_d  = '0;
                end else if (cnt_q == '0) begin
                    gear_d = target_q;
                end else begin
                    clutch_d = 1'b1;
                    cnt_d    = cnt_q - CW'(1);
                end
            end
            default: begin
                gear_d = '0;
                cnt_d  = '0;
            end
        endcase
    end

    assign bus.gear   = gear_q;
    assign bus.clutch = clutch_q;
    assign bus.denied = denied_q;
endmodule

// File: tb/tb_auto_gearbox_ctrl.sv
// tb/tb_auto_gearbox_ctrl.sv - directed self-checking bench for auto_gearbox_ctrl
module tb_auto_gearbox_ctrl;
    localparam int NUM_GEARS    = 4;
    localparam int SPEED_W      = 8;
    localparam int UP_STEP      = 40;
    localparam int HYST         = 8;
    localparam int SHIFT_CYCLES = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    auto_gearbox_ctrl_if #(.NUM_GEARS(NUM_GEARS), .SPEED_W(SPEED_W)) bus ();

    auto_gearbox_ctrl #(
        .NUM_GEARS   (NUM_GEARS),
        .SPEED_W     (SPEED_W),
        .UP_STEP     (UP_STEP),
        .HYST        (HYST),
        .SHIFT_CYCLES(SHIFT_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.drive    = 1'b0;
        bus.manual   = 1'b0;
        bus.up_req   = 1'b0;
        bus.down_req = 1'b0;
        bus.kickdown = 1'b0;
        bus.speed    = '0;
    endtask

    task automatic apply_reset;
        clear_inputs();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    // Called just after a decision edge; follows the clutch window to its end
    // (bounded) and reports edges since the decision and samples with clutch high.
    task automatic measure_shift(output int edges, output int clutch_samples);
        edges          = 0;
        clutch_samples = (bus.clutch === 1'b1) ? 1 : 0;
        while (bus.clutch === 1'b1 && edges < 40) begin
            tick(1);
            edges++;
            if (bus.clutch === 1'b1) clutch_samples++;
        end
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b0;
        tick(2);
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.gear !== 0) begin failures++; $display("FAIL reset_gear: got %0d expected 0", bus.gear); end
        checks++; if (bus.clutch !== 1'b0) begin failures++; $display("FAIL reset_clutch: got %b expected 0", bus.clutch); end
        checks++; if (bus.denied !== 1'b0) begin failures++; $display("FAIL reset_denied: got %b expected 0", bus.denied); end
        tick(1);
        rst = 1'b0;
        tick(1);
        checks++; if (bus.gear !== 0) begin failures++; $display("FAIL release_gear: got %0d expected 0", bus.gear); end
        bus.drive = 1'b1;
        tick(1);
        checks++; if (bus.gear !== 1) begin failures++; $display("FAIL engage_gear: got %0d expected 1", bus.gear); end
        checks++; if (bus.clutch !== 1'b0) begin failures++; $display("FAIL engage_clutch: got %b expected 0", bus.clutch); end
        tick(3);
        checks++; if (bus.gear !== 1 || bus.clutch !== 1'b0) begin
            failures++; $display("FAIL engage_hold: gear %0d clutch %b expected 1/0", bus.gear, bus.clutch);
        end
    endtask

    task automatic test_auto_ramp;
        int e, c;
        logic seen;
        apply_reset();
        bus.drive = 1'b1;
        bus.speed = 8'd200;
        tick(1);
        checks++; if (bus.gear !== 1 || bus.clutch !== 1'b0) begin
            failures++; $display("FAIL ramp_engage: gear %0d clutch %b expected 1/0", bus.gear, bus.clutch);
        end
        for (int g = 2; g <= 4; g++) begin
            tick(1);
            checks++; if (bus.clutch !== 1'b1) begin failures++; $display("FAIL ramp_clutch_rise_%0d: got %b expected 1", g, bus.clutch); end
            measure_shift(e, c);
            checks++; if (e != 16 || c != 16 || bus.gear !== g) begin
                failures++; $display("FAIL ramp_shift_%0d: edges %0d clutch %0d gear %0d expected 16/16/%0d", g, e, c, bus.gear, g);
            end
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (bus.clutch !== 1'b0) seen = 1'b1;
        end
        checks++; if (bus.gear !== 4 || seen !== 1'b0) begin
            failures++; $display("FAIL ramp_top: gear %0d clutch_seen %b expected 4/0", bus.gear, seen);
        end
    endtask

    task automatic test_hysteresis;
        int e, c;
        logic seen;
        apply_reset();
        bus.drive = 1'b1;
        bus.speed = 8'd60;
        tick(2);
        measure_shift(e, c);
        checks++; if (bus.gear !== 2) begin failures++; $display("FAIL hyst_setup: gear %0d expected 2", bus.gear); end
        bus.speed = 8'd35;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (bus.clutch !== 1'b0) seen = 1'b1;
        end
        checks++; if (bus.gear !== 2 || seen !== 1'b0) begin
            failures++; $display("FAIL hyst_hold35: gear %0d clutch_seen %b expected 2/0", bus.gear, seen);
        end
        bus.speed = 8'd31;
        tick(1);
        measure_shift(e, c);
        checks++; if (e != 16 || c != 16 || bus.gear !== 1) begin
            failures++; $display("FAIL hyst_down31: edges %0d clutch %0d gear %0d expected 16/16/1", e, c, bus.gear);
        end
        bus.speed = 8'd40;
        tick(1);
        measure_shift(e, c);
        checks++; if (e != 16 || bus.gear !== 2) begin
            failures++; $display("FAIL hyst_up40: edges %0d gear %0d expected 16/2", e, bus.gear);
        end
        tick(5);
        checks++; if (bus.gear !== 2 || bus.clutch !== 1'b0) begin
            failures++; $display("FAIL hyst_settle: gear %0d clutch %b expected 2/0", bus.gear, bus.clutch);
        end
    endtask

    task automatic test_manual;
        int e, c;
        apply_reset();
        bus.drive = 1'b1;
        bus.speed = 8'd100;
        tick(2);
        measure_shift(e, c);
        tick(1);
        measure_shift(e, c);
        checks++; if (bus.gear !== 3) begin failures++; $display("FAIL man_setup: gear %0d expected 3", bus.gear); end
        bus.manual   = 1'b1;
        bus.down_req = 1'b1;
        tick(1);
        bus.down_req = 1'b0;
        checks++; if (bus.denied !== 1'b1 || bus.clutch !== 1'b0) begin
            failures++; $display("FAIL man_down_overrev: denied %b clutch %b expected 1/0", bus.denied, bus.clutch);
        end
        tick(1);
        checks++; if (bus.denied !== 1'b0 || bus.gear !== 3) begin
            failures++; $display("FAIL man_deny_single: denied %b gear %0d expected 0/3", bus.denied, bus.gear);
        end
        bus.speed    = 8'd70;
        bus.down_req = 1'b1;
        tick(1);
        bus.down_req = 1'b0;
        measure_shift(e, c);
        checks++; if (e != 16 || c != 16 || bus.gear !== 2) begin
            failures++; $display("FAIL man_down70: edges %0d clutch %0d gear %0d expected 16/16/2", e, c, bus.gear);
        end
        bus.speed  = 8'd20;
        bus.up_req = 1'b1;
        tick(1);
        bus.up_req = 1'b0;
        checks++; if (bus.denied !== 1'b1 || bus.clutch !== 1'b0) begin
            failures++; $display("FAIL man_up_lug: denied %b clutch %b expected 1/0", bus.denied, bus.clutch);
        end
        bus.speed = 8'd200;
        for (int g = 3; g <= 4; g++) begin
            bus.up_req = 1'b1;
            tick(1);
            bus.up_req = 1'b0;
            measure_shift(e, c);
            checks++; if (e != 16 || bus.gear !== g) begin
                failures++; $display("FAIL man_up_%0d: edges %0d gear %0d expected 16/%0d", g, e, bus.gear, g);
            end
        end
        bus.up_req = 1'b1;
        tick(1);
        bus.up_req = 1'b0;
        checks++; if (bus.denied !== 1'b1 || bus.clutch !== 1'b0 || bus.gear !== 4) begin
            failures++; $display("FAIL man_up_top: denied %b clutch %b gear %0d expected 1/0/4", bus.denied, bus.clutch, bus.gear);
        end
    endtask

    task automatic test_kickdown;
        int e, c;
        logic seen;
        apply_reset();
        bus.drive = 1'b1;
        bus.speed = 8'd100;
        tick(2);
        measure_shift(e, c);
        tick(1);
        measure_shift(e, c);
        bus.speed = 8'd75;
        tick(5);
        checks++; if (bus.gear !== 3 || bus.clutch !== 1'b0) begin
            failures++; $display("FAIL kick_setup: gear %0d clutch %b expected 3/0", bus.gear, bus.clutch);
        end
        bus.kickdown = 1'b1;
        tick(1);
        bus.kickdown = 1'b0;
        measure_shift(e, c);
        checks++; if (e != 16 || c != 16 || bus.gear !== 2) begin
            failures++; $display("FAIL kick_down: edges %0d clutch %0d gear %0d expected 16/16/2", e, c, bus.gear);
        end
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (bus.clutch !== 1'b0) seen = 1'b1;
        end
        checks++; if (bus.gear !== 2 || seen !== 1'b0) begin
            failures++; $display("FAIL kick_hold: gear %0d clutch_seen %b expected 2/0", bus.gear, seen);
        end
        bus.kickdown = 1'b1;
        tick(1);
        bus.kickdown = 1'b0;
        checks++; if (bus.denied !== 1'b1 || bus.clutch !== 1'b0) begin
            failures++; $display("FAIL kick_refused: denied %b clutch %b expected 1/0", bus.denied, bus.clutch);
        end
    endtask

    task automatic test_abort_conflict;
        apply_reset();
        bus.drive = 1'b1;
        bus.speed = 8'd60;
        tick(2);
        tick(4);
        checks++; if (bus.clutch !== 1'b1 || bus.gear !== 1) begin
            failures++; $display("FAIL abort_mid: clutch %b gear %0d expected 1/1", bus.clutch, bus.gear);
        end
        bus.drive = 1'b0;
        tick(1);
        checks++; if (bus.gear !== 0 || bus.clutch !== 1'b0) begin
            failures++; $display("FAIL abort_drive: gear %0d clutch %b expected 0/0", bus.gear, bus.clutch);
        end
        bus.drive = 1'b1;
        tick(2);
        tick(3);
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.gear !== 0 || bus.clutch !== 1'b0 || bus.denied !== 1'b0) begin
            failures++; $display("FAIL abort_rst: gear %0d clutch %b denied %b expected 0/0/0", bus.gear, bus.clutch, bus.denied);
        end
        tick(1);
        rst = 1'b0;
        bus.manual = 1'b1;
        tick(1);
        checks++; if (bus.gear !== 1) begin failures++; $display("FAIL abort_reengage: gear %0d expected 1", bus.gear); end
        bus.up_req   = 1'b1;
        bus.down_req = 1'b1;
        tick(1);
        bus.up_req   = 1'b0;
        bus.down_req = 1'b0;
        checks++; if (bus.denied !== 1'b1 || bus.clutch !== 1'b0) begin
            failures++; $display("FAIL conflict_deny: denied %b clutch %b expected 1/0", bus.denied, bus.clutch);
        end
        tick(1);
        checks++; if (bus.denied !== 1'b0 || bus.clutch !== 1'b0 || bus.gear !== 1) begin
            failures++; $display("FAIL conflict_after: denied %b clutch %b gear %0d expected 0/0/1", bus.denied, bus.clutch, bus.gear);
        end
        bus.manual = 1'b0;
        bus.speed  = 8'd35;
        bus.up_req = 1'b1;
        tick(1);
        bus.up_req = 1'b0;
        checks++; if (bus.denied !== 1'b0 || bus.clutch !== 1'b0) begin
            failures++; $display("FAIL auto_ignore_up: denied %b clutch %b expected 0/0", bus.denied, bus.clutch);
        end
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_auto_ramp();
        test_hysteresis();
        test_manual();
        test_kickdown();
        test_abort_conflict();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/auto_gearbox_ctrl.md
Name: auto_gearbox_ctrl

Overview:
Parametrised automatic/manual gearbox controller for the FSM gearbox tile. It is the generalised successor of the fixed-gear FSM.
- Supports N forward gears plus neutral.
- Speed thresholds with downshift hysteresis.
- Timed clutch/shift window.
- Kickdown request.
- Manual mode with over-rev and lugging protection.
It sits between the speed-sensor/button input logic and the gear-indicator/clutch output drivers.

Parameters:
NUM_GEARS, 4, forward gears (2..7); gear code 0 = neutral.
SPEED_W, 8, speed input width (unsigned).
UP_STEP, 40, speed per gear; upshift from g when speed >= g*UP_STEP.
HYST, 8, hysteresis; auto downshift from g when speed < (g-1)*UP_STEP - HYST.
SHIFT_CYCLES, 16, clutch-engaged cycles per shift (>=1).
GW (localparam), clog2(NUM_GEARS+1), gear code width.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
drive  in  1  1 = drive selected; 0 = neutral.
manual  in  1  1 = manual mode (auto shifting disabled).
up_req  in  1  manual upshift request, single-cycle pulse.
down_req  in  1  manual downshift request, single-cycle pulse.
kickdown  in  1  full-throttle downshift request, pulse; valid in both modes.
speed  in  SPEED_W  current vehicle speed, unsigned.
gear  out  GW  committed gear (0 = neutral).
clutch  out  1  high while a shift is in progress.
denied  out  1  one-cycle pulse when a request is refused.

Behaviour:
- Reset (async, any time, including mid-shift): state=NEUTRAL, gear=0, clutch=0, denied=0, shift counter=0.
- Threshold arithmetic:
  - Done at width SPEED_W+GW+1, so there is no overflow.
  - Up(g)=g*UP_STEP.
  - Dn(g)=(g-1)*UP_STEP-HYST. If this is negative, the downshift condition is never true.
- State machine, three states:
  - NEUTRAL: gear=0, clutch=0. When drive=1, the next edge sets gear=1 and enters DRIVE. No clutch window.
  - DRIVE (gear g, clutch=0), evaluated each edge, priority top-down:
    1. drive=0 -> NEUTRAL, gear=0.
    2. kickdown, or (manual and down_req):
       - Allowed if g>1 and speed < Up(g-1). Then target=g-1 and enter SHIFT.
       - Otherwise denied=1 for one cycle.
    3. manual and up_req:
       - Allowed if g<NUM_GEARS and speed >= Dn(g+1). Then target=g+1 and enter SHIFT.
       - Otherwise denied pulse.
    4. Not manual:
       - speed >= Up(g) and g<NUM_GEARS -> target=g+1.
       - Else speed < Dn(g) and g>1 -> target=g-1.
       - A valid target enters SHIFT.
    - If up_req and down_req arrive in the same cycle, both are refused: denied pulse, no shift. This holds in either mode.
    - In auto mode, up_req and down_req are ignored. They produce no denied pulse.
  - SHIFT:
    - clutch=1 from the edge that enters SHIFT. Counter loads SHIFT_CYCLES-1 and decrements each edge.
    - On the edge where the counter is 0, gear<=target, clutch<=0, and the state returns to DRIVE.
    - Shift latency: gear changes exactly SHIFT_CYCLES edges after the decision edge. clutch is high for exactly SHIFT_CYCLES cycles.
    - All requests during SHIFT are ignored and produce no denied pulse. Speed changes during SHIFT do not alter target.
    - drive=0 during SHIFT aborts the shift: next edge gives gear=0, clutch=0, NEUTRAL.
- Only one gear step per shift. Re-evaluation happens on the first DRIVE cycle after the shift, so gears climb one step at a time.
- Outputs are registered. denied is never high for two consecutive cycles from a single request pulse.

Test Plan:
(Defaults throughout: NUM_GEARS=4, UP_STEP=40, HYST=8, SHIFT_CYCLES=16.)
1. Reset and engage: assert rst mid-clock, then release with speed=0 -> gear=0, clutch=0, denied=0 immediately. Set drive=1 -> gear=1 after one edge, clutch stays 0.
2. Auto ramp: drive=1, auto mode, speed=200 held.
   - clutch rises one edge after entering DRIVE.
   - gear=2 16 edges later, then 3, then 4, each shift with clutch high for 16 cycles.
   - gear stays 4 with no further clutch activity.
3. Hysteresis in gear 2:
   - speed=35 -> no shift for 100 cycles.
   - speed=31 -> clutch high for 16 cycles, then gear=1.
   - speed=40 -> upshift back to 2.
4. Manual protection in gear 3, manual=1:
   - speed=100, down_req -> denied pulse, gear stays 3.
   - speed=70, down_req -> gear=2 after 16 cycles.
   - speed=20, up_req -> denied, because 20 < Dn(3)=72.
   - At gear 4, up_req -> denied.
5. Kickdown in auto mode: gear 3, speed=75, kickdown pulse -> gear=2 after 16 cycles, and it stays 2 because 75 < 80 and 75 >= 32.
6. Aborts and conflicts:
   - drive=0 at cycle 5 of a shift -> gear=0, clutch=0 next edge.
   - rst asserted mid-shift -> outputs zero asynchronously.
   - up_req and down_req together in manual mode -> single denied pulse, no clutch.
